// File: rtl/load_store_unit_if.sv
// Request, data-memory and response signals of the load/store unit.
// master = upstream/memory side (the environment), slave = the unit itself.
interface load_store_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] endereco;
    logic [31:0] dado_store;
    logic [4:0]  rd;
    logic [31:0] mem_posicao;
    logic [31:0] mem_dados;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_saida;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dado;
    logic [4:0]  out_rd;
    logic        out_is_load;
    logic        erro_alinh;
    logic        erro_faixa;

    modport master (
        output in_valid, op, endereco, dado_store, rd, mem_saida, out_ready,
        input  in_ready, mem_posicao, mem_dados, mem_write, mem_read,
               out_valid, out_dado, out_rd, out_is_load, erro_alinh, erro_faixa
    );

    modport slave (
        input  in_valid, op, endereco, dado_store, rd, mem_saida, out_ready,
        output in_ready, mem_posicao, mem_dados, mem_write, mem_read,
               out_valid, out_dado, out_rd, out_is_load, erro_alinh, erro_faixa
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half stores done as
// read-modify-write on a word-wide data memory, result held until taken.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input logic             clk,
    input logic             rst_n,
    load_store_unit_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] STORE  = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    localparam logic [31:0] BYTE_RANGE = 32'(4 * MEM_WORDS);

    logic [2:0]  state_reg, state_next;
    logic [2:0]  op_reg;
    logic [31:0] endereco_reg;
    logic [31:0] dado_store_reg;
    logic [4:0]  rd_reg;
    logic [31:0] word_reg;
    logic [31:0] out_dado_reg;
    logic        out_is_load_reg;
    logic        erro_alinh_reg;
    logic        erro_faixa_reg;

    logic        in_is_load;
    logic        in_alinh;
    logic        in_faixa;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic [31:0] byte_lane;
    logic [15:0] half_lane;

    // Decode the request currently on the input bus (used only on accept).
    always_comb begin
        in_is_load = !((bus.op == OP_SB) || (bus.op == OP_SH) || (bus.op == OP_SW));
        in_alinh   = (((bus.op == OP_LH) || (bus.op == OP_LHU) || (bus.op == OP_SH)) && bus.endereco[0])
                   || (((bus.op == OP_LW) || (bus.op == OP_SW)) && (bus.endereco[1:0] != 2'b00));
        in_faixa   = (bus.endereco >= BYTE_RANGE);
    end

    // Next-state: errors skip memory entirely; sub-word stores take the RMW path.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    if (in_alinh || in_faixa)     state_next = RESP;
                    else if (in_is_load)          state_next = LOAD;
                    else if (bus.op == OP_SW)     state_next = STORE;
                    else                          state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            STORE:   state_next = RESP;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = RESP;
            RESP:    state_next = bus.out_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Little-endian lane extraction with sign/zero extension for loads.
    always_comb begin
        byte_lane = bus.mem_saida >> {endereco_reg[1:0], 3'b000};
        half_lane = endereco_reg[1] ? bus.mem_saida[31:16] : bus.mem_saida[15:0];
        case (op_reg)
            OP_LB:   load_value = {{24{byte_lane[7]}}, byte_lane[7:0]};
            OP_LBU:  load_value = {24'b0, byte_lane[7:0]};
            OP_LH:   load_value = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_value = {16'b0, half_lane};
            default: load_value = bus.mem_saida;
        endcase
    end

    // Per-lane merge of the store data into the word read during RMW_RD.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       lane_hit;
        logic [7:0] store_byte;
        assign lane_hit   = (op_reg == OP_SB) ? (endereco_reg[1:0] == LANE)
                                              : (endereco_reg[1] == LANE[1]);
        assign store_byte = (op_reg == OP_SB) ? dado_store_reg[7:0]
                                              : dado_store_reg[8*(gi%2) +: 8];
        assign merged_word[8*gi +: 8] = lane_hit ? store_byte : word_reg[8*gi +: 8];
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            op_reg          <= '0;
            endereco_reg    <= '0;
            dado_store_reg  <= '0;
            rd_reg          <= '0;
            word_reg        <= '0;
            out_dado_reg    <= '0;
            out_is_load_reg <= 1'b0;
            erro_alinh_reg  <= 1'b0;
            erro_faixa_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && bus.in_valid) begin
                op_reg          <= bus.op;
                endereco_reg    <= bus.endereco;
                dado_store_reg  <= bus.dado_store;
                rd_reg          <= bus.rd;
                out_dado_reg    <= '0;
                out_is_load_reg <= in_is_load;
                erro_alinh_reg  <= in_alinh;
                erro_faixa_reg  <= in_faixa;
            end
            if (state_reg == LOAD)   out_dado_reg <= load_value;
            if (state_reg == RMW_RD) word_reg     <= bus.mem_saida;
        end
    end

    // Memory strobes and response outputs decoded from the current state.
    always_comb begin
        bus.in_ready    = (state_reg == IDLE);
        bus.out_valid   = (state_reg == RESP);
        bus.mem_read    = (state_reg == LOAD) || (state_reg == RMW_RD);
        bus.mem_write   = (state_reg == STORE) || (state_reg == RMW_WR);
        bus.mem_posicao = '0;
        if ((state_reg == LOAD) || (state_reg == STORE) ||
            (state_reg == RMW_RD) || (state_reg == RMW_WR))
            bus.mem_posicao = {2'b00, endereco_reg[31:2]};
        bus.mem_dados   = '0;
        if (state_reg == STORE)       bus.mem_dados = dado_store_reg;
        else if (state_reg == RMW_WR) bus.mem_dados = merged_word;
        bus.out_dado    = out_dado_reg;
        bus.out_rd      = rd_reg;
        bus.out_is_load = out_is_load_reg;
        bus.erro_alinh  = erro_alinh_reg;
        bus.erro_faixa  = erro_faixa_reg;
    end
endmodule
